// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and byte-level helper functions.
// Imported by the round datapath, the sequencer and its bus interface.
package aes128_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [127:0] aes_key_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    // Round constant for key-schedule step rnd (1..10); 0 outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one 32-bit column, row 0 in the top byte.
    function automatic aes_word_t mix_column(input aes_word_t col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Host-side handshake bundle of the AES-128 sequencer: plaintext/key in,
// ciphertext out, plus the round-index status.
interface aes128_round_sequencer_if;
    import aes128_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t data_in;
    aes_key_t   key_in;
    logic       out_valid;
    logic       out_ready;
    aes_block_t data_out;
    logic [3:0] round_idx;

    // Host / bus side.
    modport master (
        output in_valid, data_in, key_in, out_ready,
        input  in_ready, out_valid, data_out, round_idx
    );

    // Sequencer side.
    modport slave (
        input  in_valid, data_in, key_in, out_ready,
        output in_ready, out_valid, data_out, round_idx
    );

endinterface

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational:
// SubBytes, ShiftRows, MixColumns (skipped when i_final), AddRoundKey.
// Byte k of the block sits at [127-8k -: 8]; byte k is row k%4, column k/4.
module aes_round_comb
    import aes128_pkg::*;
(
    input  aes_block_t i_st,
    input  aes_key_t   i_rk,
    input  logic       i_final,
    output aes_block_t o_st
);

    aes_block_t w_sub;
    aes_block_t w_shift;
    aes_block_t w_mix;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub
            assign w_sub[127 - 8*gi -: 8] = sbox(i_st[127 - 8*gi -: 8]);
        end

        // Row r is rotated left by r columns: out(r,c) = in(r,(c+r)%4).
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign w_shift[127 - 8*gi -: 8] = w_sub[127 - 8*SRC -: 8];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            assign w_mix[127 - 32*gi -: 32] = mix_column(w_shift[127 - 32*gi -: 32]);
        end
    endgenerate

    assign o_st = (i_final ? w_shift : w_mix) ^ i_rk;

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption controller: accepts a plaintext/key pair,
// runs one round per cycle with an on-the-fly key schedule, then holds the
// ciphertext on a valid/ready output until the consumer takes it.
module aes128_round_sequencer
    import aes128_pkg::*;
#(
    parameter int NR        = NR_AES128,
    parameter bit OUT_CLEAR = 1'b1
)(
    input  logic                       CLK,
    input  logic                       RST,
    aes128_round_sequencer_if.slave    bus
);

    // Only the AES-128 round count is supported.
    if (NR != NR_AES128) begin : g_nr_check
        $error("aes128_round_sequencer: NR must be 10");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    aes_state_e r_state;
    aes_block_t r_st;
    aes_key_t   r_rk;
    logic [3:0] r_rnd;
    logic       r_in_ready;
    logic       r_out_valid;
    aes_block_t r_data_out;
    logic [3:0] r_round_idx;

    aes_word_t  w_rot_word;
    aes_word_t  w_sub_word;
    aes_word_t  w_nk0, w_nk1, w_nk2, w_nk3;
    aes_key_t   w_nk;
    aes_block_t w_st_next;
    logic       w_final;

    // Key schedule step: RotWord/SubWord of the last word, then a running XOR.
    assign w_rot_word = {r_rk[23:0], r_rk[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign w_sub_word[31 - 8*gi -: 8] = sbox(w_rot_word[31 - 8*gi -: 8]);
        end
    endgenerate

    assign w_nk0 = r_rk[127:96] ^ w_sub_word ^ {rcon(r_rnd), 24'h000000};
    assign w_nk1 = r_rk[95:64]  ^ w_nk0;
    assign w_nk2 = r_rk[63:32]  ^ w_nk1;
    assign w_nk3 = r_rk[31:0]   ^ w_nk2;
    assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

    assign w_final = (r_rnd == NR_L);

    aes_round_comb u_round (
        .i_st    (r_st),
        .i_rk    (w_nk),
        .i_final (w_final),
        .o_st    (w_st_next)
    );

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rk        <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_round_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_st        <= bus.data_in ^ bus.key_in;
                        r_rk        <= bus.key_in;
                        r_rnd       <= 4'd1;
                        r_round_idx <= 4'd1;
                        r_in_ready  <= 1'b0;
                        r_state     <= ROUND;
                    end
                end
                ROUND: begin
                    r_rk  <= w_nk;
                    r_st  <= w_st_next;
                    r_rnd <= r_rnd + 4'd1;
                    if (w_final) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                        r_data_out  <= w_st_next;
                        r_round_idx <= 4'd0;
                    end else begin
                        r_round_idx <= r_rnd + 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        if (OUT_CLEAR) begin
                            r_data_out <= '0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_round_idx <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.round_idx = r_round_idx;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: FIPS-197 vector table, random vectors
// against a byte-level AES reference model, and hand-written sequences for
// backpressure, mid-block reset and back-to-back operation.
module tb_aes128_round_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    aes128_round_sequencer_if bus_if();

    aes128_round_sequencer #(
        .NR        (10),
        .OUT_CLEAR (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]   ref_sb [256];
    int           acc_q [$];
    logic [127:0] out_q [$];

    typedef struct packed {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] rk1;
    } vec_t;

    vec_t vecs [3];

    always @(posedge CLK) cyc <= cyc + 1;

    // Transfer monitor, sampled mid-cycle before the edge that completes it.
    always @(negedge CLK) begin
        if (!RST && bus_if.in_valid && bus_if.in_ready)
            acc_q.push_back(cyc);
        if (!RST && bus_if.out_valid && bus_if.out_ready)
            out_q.push_back(bus_if.data_out);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                                 output logic [127:0] rk1);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {ref_sb[tmp[31:24]], ref_sb[tmp[23:16]], ref_sb[tmp[15:8]], ref_sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        rk1 = {w[4], w[5], w[6], w[7]};
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[r + 4*c] = gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1)%4])
                                   ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
            end
            for (int c = 0; c < 4; c++) begin
                tmp = w[4*rnd + c];
                for (int r = 0; r < 4; r++) s[r + 4*c] = s[r + 4*c] ^ tmp[31 - 8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full transaction: accept, scramble inputs during ROUND, check latency,
    // ciphertext and (optionally) round-1 key / round index, then drain.
    task automatic do_block(input string nm, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct, input logic [127:0] rk1,
                            input bit chk_rk, input bit chk_idx);
        int k;
        k = 0;
        while (bus_if.in_ready !== 1'b1 && k < 40) begin tick(); k++; end
        chk({nm, "_in_ready"}, 128'(bus_if.in_ready), 128'd1);
        bus_if.data_in  = pt;
        bus_if.key_in   = key;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.data_in  = rand128();
        bus_if.key_in   = rand128();
        if (chk_idx) chk({nm, "_idx_r1"}, 128'(bus_if.round_idx), 128'd1);
        k = 0;
        while (bus_if.out_valid !== 1'b1 && k < 30) begin
            tick();
            k++;
            if (chk_rk && k == 1) chk({nm, "_rk1"}, dut.r_rk, rk1);
            if (chk_idx && k == 5) chk({nm, "_idx_r6"}, 128'(bus_if.round_idx), 128'd6);
            bus_if.data_in = rand128();
            bus_if.key_in  = rand128();
        end
        chk({nm, "_latency"}, 128'(k), 128'd10);
        chk({nm, "_ct"}, bus_if.data_out, ct);
        if (chk_idx) chk({nm, "_idx_hold"}, 128'(bus_if.round_idx), 128'd0);
        $display("blk %s pt=%h key=%h ct=%h lat=%0d", nm, pt, key, bus_if.data_out, k);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        chk({nm, "_ov_after"}, 128'(bus_if.out_valid), 128'd0);
        chk({nm, "_dout_clr"}, bus_if.data_out, 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] pt, key, ct, rk1, ct_b, pt_b, key_b;
        int k;

        for (int i = 0; i < 256; i++) ref_sb[i] = calc_sbox(8'(i));

        vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32, rk1: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, rk1: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[2] = '{pt: 128'h0, key: 128'h0,
                    ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, rk1: 128'h62636363626363636263636362636363};

        // Reset, with in_valid asserted to show reset wins.
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        bus_if.data_in   = rand128();
        bus_if.key_in    = rand128();
        repeat (3) tick();
        chk("rst_in_ready",  128'(bus_if.in_ready),  128'd1);
        chk("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
        chk("rst_data_out",  bus_if.data_out,        128'd0);
        chk("rst_round_idx", 128'(bus_if.round_idx), 128'd0);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        RST = 1'b0;
        tick();

        // Known-answer table.
        for (int i = 0; i < 3; i++)
            do_block($sformatf("fips%0d", i), vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].rk1, 1'b1, 1'b1);

        // Random vectors against the reference model.
        for (int i = 0; i < 6; i++) begin
            pt  = rand128();
            key = rand128();
            ct  = ref_encrypt(pt, key, rk1);
            do_block($sformatf("rand%0d", i), pt, key, ct, rk1, 1'b1, 1'b0);
        end

        // Backpressure: hold off the consumer for 20 cycles while in_valid pulses.
        acc_q.delete(); out_q.delete();
        bus_if.data_in = vecs[0].pt; bus_if.key_in = vecs[0].key; bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        k = 0;
        while (bus_if.out_valid !== 1'b1 && k < 30) begin tick(); k++; end
        chk("bp_latency", 128'(k), 128'd10);
        for (int i = 0; i < 20; i++) begin
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.data_in  = rand128();
            bus_if.key_in   = rand128();
            tick();
            chk($sformatf("bp_dout_%0d", i), bus_if.data_out, vecs[0].ct);
            chk($sformatf("bp_rdy_%0d", i), 128'(bus_if.in_ready), 128'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        chk("bp_ov_release",  128'(bus_if.out_valid), 128'd0);
        chk("bp_rdy_release", 128'(bus_if.in_ready),  128'd1);
        tick();
        chk("bp_handshakes", 128'(out_q.size()), 128'd1);
        chk("bp_accepts",    128'(acc_q.size()), 128'd1);
        if (out_q.size() > 0) chk("bp_ct", out_q[0], vecs[0].ct);
        $display("blk backpressure handshakes=%0d accepts=%0d", out_q.size(), acc_q.size());

        // Reset in the middle of round 5, then a clean block.
        bus_if.data_in = vecs[1].pt; bus_if.key_in = vecs[1].key; bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (4) tick();
        chk("mr_idx_before", 128'(bus_if.round_idx), 128'd5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mr_out_valid", 128'(bus_if.out_valid), 128'd0);
        chk("mr_in_ready",  128'(bus_if.in_ready),  128'd1);
        chk("mr_round_idx", 128'(bus_if.round_idx), 128'd0);
        $display("blk midreset round_idx=%0d", bus_if.round_idx);
        do_block("after_rst", vecs[0].pt, vecs[0].key, vecs[0].ct, vecs[0].rk1, 1'b1, 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete(); out_q.delete();
        pt_b  = rand128();
        key_b = rand128();
        ct_b  = ref_encrypt(pt_b, key_b, rk1);
        bus_if.data_in = vecs[1].pt; bus_if.key_in = vecs[1].key;
        bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b1;
        k = 0;
        while (acc_q.size() < 1 && k < 20) begin tick(); k++; end
        for (int i = 0; i < 6; i++) begin
            bus_if.data_in = rand128(); bus_if.key_in = rand128();
            tick();
        end
        bus_if.data_in = pt_b; bus_if.key_in = key_b;
        k = 0;
        while (acc_q.size() < 2 && k < 30) begin tick(); k++; end
        bus_if.in_valid = 1'b0;
        k = 0;
        while (out_q.size() < 2 && k < 40) begin tick(); k++; end
        bus_if.out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_q.size()), 128'd2);
        chk("b2b_outputs", 128'(out_q.size()), 128'd2);
        if (acc_q.size() >= 2) chk("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd12);
        if (out_q.size() >= 1) chk("b2b_ct0", out_q[0], vecs[1].ct);
        if (out_q.size() >= 2) chk("b2b_ct1", out_q[1], ct_b);
        $display("blk back_to_back accepts=%0d outputs=%0d", acc_q.size(), out_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
